hwpe_tcdm_bank_responder: RTL and testbench
===========================================

Name: hwpe_tcdm_bank_responder

Overview:
- Multi-port, word-interleaved TCDM slave memory model. It is the responder end of the hwpe_stream_intf_tcdm master ports driven by an HWPE streamer.
- Used as the memory side of HWPE block-level testbenches and standalone FPGA shells, in place of the cluster TCDM interconnect plus SRAM banks.
- Per-bank round-robin arbitration, fixed 1-cycle response latency, optional pseudo-random grant stalls and a conflict counter for verification.

Parameters:
- MP, 3: number of TCDM slave ports.
- NB, 4: number of banks; power of 2, ≥1.
- DEPTH, 256: 32-bit words per bank; power of 2.
- STALL_EN, 0: 1 = enable LFSR-driven grant suppression.
- LFSR_SEED, 16'hACE1: reset value of the 16-bit stall LFSR; must be nonzero.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, synchronous, active-low
- clear_i  in  1  synchronous clear of arbiter pointers, LFSR and conflict counter; memory contents kept
- tcdm_req_i  in  MP  per-port request
- tcdm_gnt_o  out  MP  per-port grant, combinational from req in the same cycle
- tcdm_add_i  in  MP×32  byte address
- tcdm_wen_i  in  MP  1 = read, 0 = write
- tcdm_be_i  in  MP×4  byte enables (writes only)
- tcdm_data_i  in  MP×32  write data
- tcdm_r_data_o  out  MP×32  read data
- tcdm_r_valid_o  out  MP  response valid
- conflict_cnt_o  out  32  count of denied-request port-cycles

Behaviour:
- Clocking and reset: one clock, clk_i. Reset is synchronous, active-low on rst_ni.
- Reset values:
  - tcdm_r_valid_o = 0, tcdm_r_data_o = 0, conflict_cnt_o = 0.
  - All round-robin pointers = 0; LFSR = LFSR_SEED.
  - tcdm_gnt_o is forced 0 while rst_ni = 0.
  - Memory contents are not reset.
- Address decode: bank = add[2 +: log2(NB)]; row = add[2+log2(NB) +: log2(DEPTH)]. add[1:0] and all higher bits are ignored, so out-of-range addresses alias modulo NB*DEPTH*4.
- Arbitration:
  - Each bank has an independent round-robin arbiter over the ports requesting it.
  - The winner is the first requesting port at or after that bank's pointer, wrapping modulo MP.
  - On a grant to port p, the pointer becomes (p+1) mod MP at the next edge. The pointer is unchanged if the bank had no grant.
  - At most one grant per bank per cycle. Ports targeting different banks are all granted in the same cycle.
- Stall injection (STALL_EN = 1):
  - 16-bit Fibonacci LFSR with taps 16,14,13,11, advancing every cycle.
  - Port p's grant is suppressed when lfsr[p mod 16] = 1.
  - A suppressed port does not consume its bank's slot; the arbiter skips it this cycle.
  - With STALL_EN = 0 the LFSR is held.
- Write (granted, wen = 0): bytes with be[i] = 1 are written at the clock edge ending the grant cycle. be = 0 is a legal no-op write.
- Read (granted, wen = 1): r_data = mem[bank][row] sampled at the grant edge, presented the next cycle.
- Response:
  - tcdm_r_valid_o[p] = 1 exactly one cycle after every granted cycle of port p, for reads and writes alike.
  - For writes, r_data = 0.
  - Otherwise r_valid = 0 and r_data holds 0.
  - Back-to-back grants produce back-to-back r_valid, with no bubble.
- Ordering:
  - A write granted in cycle N is visible to any read granted in cycle N+1 or later.
  - Same-bank accesses in one cycle are impossible by construction (one grant per bank).
- Conflict counter:
  - Increments by the number of ports with req = 1 and gnt = 0 in the cycle, whether denied by arbitration or by a stall.
  - Saturates at 2^32-1.
  - clear_i has priority over the increment.
- Request semantics: an ungranted request carries no state. The master holds req/add/wen/data until granted; the block does not check this.
- Reset mid-operation: a pending r_valid is dropped. Memory writes of the reset cycle are still performed if granted before reset asserted; with rst_ni = 0, gnt = 0, so no new writes occur.

Test Plan:
1. Single-port write then read: port0 write add=0x10, data=0xDEADBEEF, be=4'hF; next cycle read 0x10 -> gnt same cycle; r_valid the cycle after each grant; read r_data = 0xDEADBEEF.
2. Byte enables: write 0x11223344 to 0x20 with be=F, then 0xAABBCCDD with be=4'b0101, then read -> 0x11BB33DD.
3. Bank conflict: ports 0,1,2 all read 0x0 (bank 0) continuously from reset -> grants in order 0,1,2,0,…; conflict_cnt_o increments by 2 per cycle; each r_valid one cycle after its grant.
4. Parallel banks: ports 0,1,2 read 0x0, 0x4, 0x8 in the same cycle -> all three granted, three r_valid next cycle, conflict_cnt_o stays 0.
5. Aliasing: write 0x5A5A5A5A to 0x0, read 0x1000 (NB=4, DEPTH=256) -> r_data = 0x5A5A5A5A.
6. Stalls and reset: STALL_EN=1, 1000 random requests on 3 ports -> every granted read returns last-written data, no r_valid without a prior grant, conflict_cnt_o = scoreboard count. Then assert rst_ni mid-burst -> next cycle all r_valid = 0, gnt = 0, conflict_cnt_o = 0.

Source files
------------

// File: rtl/hwpe_tcdm_bank_responder.sv
// Word-interleaved multi-port TCDM responder: per-bank round-robin arbitration, fixed 1-cycle
// response latency, optional LFSR-driven grant stalls and a saturating conflict counter.
module hwpe_tcdm_bank_responder #(
    parameter int unsigned MP        = 3,
    parameter int unsigned NB        = 4,
    parameter int unsigned DEPTH     = 256,
    parameter int unsigned STALL_EN  = 0,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic [MP-1:0]    tcdm_req_i,
    output logic [MP-1:0]    tcdm_gnt_o,
    input  logic [MP*32-1:0] tcdm_add_i,
    input  logic [MP-1:0]    tcdm_wen_i,
    input  logic [MP*4-1:0]  tcdm_be_i,
    input  logic [MP*32-1:0] tcdm_data_i,
    output logic [MP*32-1:0] tcdm_r_data_o,
    output logic [MP-1:0]    tcdm_r_valid_o,
    output logic [31:0]      conflict_cnt_o
);

    localparam int unsigned BankBits = $clog2(NB);
    localparam int unsigned BankW    = (NB > 1) ? BankBits : 1;
    localparam int unsigned RowW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned PtrW     = (MP > 1) ? $clog2(MP) : 1;

    logic [31:0]      mem_q [NB][DEPTH];

    logic [BankW-1:0] bank [MP];
    logic [RowW-1:0]  row  [MP];
    logic [MP-1:0]    stall;
    logic [MP-1:0]    gnt;

    logic [PtrW-1:0]  rr_q [NB];
    logic [PtrW-1:0]  rr_d [NB];
    logic [15:0]      lfsr_q, lfsr_d;
    logic [31:0]      cnt_q, cnt_d;
    logic [MP-1:0]    r_valid_q, r_valid_d;
    logic [MP*32-1:0] r_data_q, r_data_d;

    // Higher address bits are dropped, so out-of-range addresses alias.
    always_comb begin
        for (int p = 0; p < MP; p++) begin
            bank[p]  = BankW'((tcdm_add_i[p*32 +: 32] >> 2) & 32'(NB - 1));
            row[p]   = RowW'((tcdm_add_i[p*32 +: 32] >> (2 + BankBits)) & 32'(DEPTH - 1));
            stall[p] = (STALL_EN != 0) && lfsr_q[p % 16];
        end
    end

    always_comb begin
        logic [PtrW-1:0] idx;
        logic            found;
        idx   = '0;
        found = 1'b0;
        gnt   = '0;
        for (int unsigned b = 0; b < NB; b++) begin
            rr_d[b] = rr_q[b];
            found   = 1'b0;
            for (int unsigned i = 0; i < MP; i++) begin
                idx = PtrW'((32'(rr_q[b]) + i) % MP);
                // Stalled ports are skipped so they do not consume the bank slot.
                if (!found && rst_ni && tcdm_req_i[idx] && !stall[idx] &&
                    (32'(bank[idx]) == b)) begin
                    found    = 1'b1;
                    gnt[idx] = 1'b1;
                    rr_d[b]  = PtrW'((32'(idx) + 1) % MP);
                end
            end
            if (clear_i) begin
                rr_d[b] = '0;
            end
        end
    end

    always_comb begin
        lfsr_d = lfsr_q;
        if (clear_i) begin
            lfsr_d = LFSR_SEED;
        end else if (STALL_EN != 0) begin
            lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
    end

    always_comb begin
        logic [31:0] deny;
        logic [32:0] sum;
        deny = '0;
        for (int p = 0; p < MP; p++) begin
            deny = deny + 32'(tcdm_req_i[p] & ~gnt[p]);
        end
        sum   = {1'b0, cnt_q} + {1'b0, deny};
        cnt_d = sum[32] ? '1 : sum[31:0];
        if (clear_i) begin
            cnt_d = '0;
        end
    end

    always_comb begin
        r_valid_d = gnt;
        r_data_d  = '0;
        for (int p = 0; p < MP; p++) begin
            if (gnt[p] && tcdm_wen_i[p]) begin
                r_data_d[p*32 +: 32] = mem_q[bank[p]][row[p]];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_valid_q <= '0;
            r_data_q  <= '0;
            cnt_q     <= '0;
            lfsr_q    <= LFSR_SEED;
            for (int b = 0; b < NB; b++) begin
                rr_q[b] <= '0;
            end
        end else begin
            r_valid_q <= r_valid_d;
            r_data_q  <= r_data_d;
            cnt_q     <= cnt_d;
            lfsr_q    <= lfsr_d;
            for (int b = 0; b < NB; b++) begin
                rr_q[b] <= rr_d[b];
            end
        end
    end

    // Storage is never reset; gnt is already forced low while in reset.
    always_ff @(posedge clk_i) begin
        for (int p = 0; p < MP; p++) begin
            for (int k = 0; k < 4; k++) begin
                if (gnt[p] && !tcdm_wen_i[p] && tcdm_be_i[p*4 + k]) begin
                    mem_q[bank[p]][row[p]][k*8 +: 8] <= tcdm_data_i[p*32 + k*8 +: 8];
                end
            end
        end
    end

    assign tcdm_gnt_o     = gnt;
    assign tcdm_r_valid_o = r_valid_q;
    assign tcdm_r_data_o  = r_data_q;
    assign conflict_cnt_o = cnt_q;

endmodule

// File: tb/tb_hwpe_tcdm_bank_responder.sv
// Bench for hwpe_tcdm_bank_responder: instance 0 without stalls runs directed vectors,
// instance 1 with stalls runs a random burst against a shadow memory; a monitor pops responses.
module tb_hwpe_tcdm_bank_responder;

    localparam int unsigned MP    = 3;
    localparam int unsigned NB    = 4;
    localparam int unsigned DEPTH = 256;

    typedef struct packed {
        logic        known;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n [2];
    logic        clear [2];
    logic [2:0]  req   [2];
    logic [2:0]  wen   [2];
    logic [31:0] add   [2][3];
    logic [31:0] wdat  [2][3];
    logic [3:0]  be    [2][3];
    logic [2:0]  gnt   [2];
    logic [2:0]  rvalid[2];
    logic [31:0] rdata [2][3];
    logic [31:0] cnt   [2];

    for (genvar d = 0; d < 2; d++) begin : g_dut
        logic [95:0] add_f, wdat_f, rdata_f;
        logic [11:0] be_f;
        assign add_f  = {add[d][2], add[d][1], add[d][0]};
        assign wdat_f = {wdat[d][2], wdat[d][1], wdat[d][0]};
        assign be_f   = {be[d][2], be[d][1], be[d][0]};
        for (genvar p = 0; p < 3; p++) begin : g_port
            assign rdata[d][p] = rdata_f[p*32 +: 32];
        end
        hwpe_tcdm_bank_responder #(
            .MP       (MP),
            .NB       (NB),
            .DEPTH    (DEPTH),
            .STALL_EN (d),
            .LFSR_SEED(16'hACE1)
        ) u_dut (
            .clk_i         (clk),
            .rst_ni        (rst_n[d]),
            .clear_i       (clear[d]),
            .tcdm_req_i    (req[d]),
            .tcdm_gnt_o    (gnt[d]),
            .tcdm_add_i    (add_f),
            .tcdm_wen_i    (wen[d]),
            .tcdm_be_i     (be_f),
            .tcdm_data_i   (wdat_f),
            .tcdm_r_data_o (rdata_f),
            .tcdm_r_valid_o(rvalid[d]),
            .conflict_cnt_o(cnt[d])
        );
    end

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc   = 0;
    logic        mon_en = 1'b0;
    exp_t        expq [2][3][$];
    logic [31:0] exp_cur [3];
    logic [31:0] shadow  [NB*DEPTH];
    logic        known_w [NB*DEPTH];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard producer: every granted cycle queues one expected response.
    always @(negedge clk) begin
        exp_t        e;
        int unsigned w;
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 3; p++) begin
                if (req[d][p] && gnt[d][p]) begin
                    e.cyc   = cyc;
                    e.known = 1'b1;
                    e.data  = '0;
                    if (wen[d][p]) begin
                        if (d == 0) begin
                            e.data = exp_cur[p];
                        end else begin
                            w       = 32'(add[1][p][11:2]);
                            e.known = known_w[w];
                            e.data  = shadow[w];
                        end
                    end
                    expq[d][p].push_back(e);
                end
            end
        end
        for (int p = 0; p < 3; p++) begin
            if (req[1][p] && gnt[1][p] && !wen[1][p]) begin
                w = 32'(add[1][p][11:2]);
                for (int k = 0; k < 4; k++) begin
                    if (be[1][p][k]) shadow[w][k*8 +: 8] = wdat[1][p][k*8 +: 8];
                end
                if (be[1][p] == 4'hF) known_w[w] = 1'b1;
            end
        end
    end

    // Scoreboard consumer: response must be one cycle after its grant, idle data is zero.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            for (int d = 0; d < 2; d++) begin
                for (int p = 0; p < 3; p++) begin
                    if (rvalid[d][p]) begin
                        if (expq[d][p].size() == 0) begin
                            n_vec++;
                            n_err++;
                            $display("FAIL rvalid_no_grant d%0d p%0d: got r_valid=1, expected 0",
                                     d, p);
                        end else begin
                            e = expq[d][p].pop_front();
                            check($sformatf("rvalid_latency d%0d p%0d", d, p), 32'(cyc),
                                  32'(e.cyc + 1));
                            if (e.known) begin
                                check($sformatf("rdata d%0d p%0d", d, p), rdata[d][p], e.data);
                            end
                        end
                    end else begin
                        check($sformatf("idle_rdata d%0d p%0d", d, p), rdata[d][p], 32'h0);
                    end
                end
            end
        end
    end

    task automatic access(input int p, input logic w, input logic [31:0] a,
                         input logic [31:0] dat, input logic [3:0] b,
                         input logic [31:0] e, output int waits);
        req[0][p]  = 1'b1;
        wen[0][p]  = w;
        add[0][p]  = a;
        wdat[0][p] = dat;
        be[0][p]   = b;
        exp_cur[p] = e;
        waits      = 0;
        @(negedge clk);
        while (!gnt[0][p] && waits < 20) begin
            waits++;
            @(negedge clk);
        end
        check("access_granted", 32'(gnt[0][p]), 32'h1);
        @(posedge clk);
        #1;
        req[0][p] = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        int          w;
        int          issued;
        int          conf_model;
        int          loops;
        logic [2:0]  gprev;
        for (int i = 0; i < NB*DEPTH; i++) begin
            shadow[i]  = '0;
            known_w[i] = 1'b0;
        end
        for (int d = 0; d < 2; d++) begin
            rst_n[d] = 1'b0;
            clear[d] = 1'b0;
            req[d]   = '0;
            wen[d]   = '1;
            for (int p = 0; p < 3; p++) begin
                add[d][p]  = '0;
                wdat[d][p] = '0;
                be[d][p]   = '0;
            end
        end
        for (int p = 0; p < 3; p++) exp_cur[p] = '0;

        // Requests during reset must never be granted.
        @(posedge clk);
        #1;
        req[0] = 3'b111;
        @(negedge clk);
        check("gnt_in_reset", 32'(gnt[0]), 32'h0);
        @(posedge clk);
        #1;
        req[0]   = '0;
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        mon_en   = 1'b1;
        @(negedge clk);
        check("reset_rvalid0", 32'(rvalid[0]), 32'h0);
        check("reset_cnt0", cnt[0], 32'h0);
        check("reset_cnt1", cnt[1], 32'h0);
        @(posedge clk);
        #1;

        // Single-port write/read, byte enables, aliasing.
        access(0, 1'b0, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, w);
        check("t1_wr_gnt_wait", 32'(w), 32'h0);
        access(0, 1'b1, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, w);
        check("t1_rd_gnt_wait", 32'(w), 32'h0);
        access(0, 1'b0, 32'h20, 32'h11223344, 4'hF, 32'h0, w);
        access(0, 1'b0, 32'h20, 32'hAABBCCDD, 4'b0101, 32'h0, w);
        access(0, 1'b1, 32'h20, 32'h0, 4'h0, 32'h11BB33DD, w);
        access(0, 1'b0, 32'h0, 32'h5A5A5A5A, 4'hF, 32'h0, w);
        access(0, 1'b1, 32'h1000, 32'h0, 4'h0, 32'h5A5A5A5A, w);
        access(1, 1'b0, 32'h4, 32'h04040404, 4'hF, 32'h0, w);
        access(2, 1'b0, 32'h8, 32'h08080808, 4'hF, 32'h0, w);

        // Parallel banks: all granted together, no conflicts.
        req[0] = 3'b111;
        wen[0] = 3'b111;
        for (int p = 0; p < 3; p++) add[0][p] = 32'(p * 4);
        exp_cur[0] = 32'h5A5A5A5A;
        exp_cur[1] = 32'h04040404;
        exp_cur[2] = 32'h08080808;
        @(negedge clk);
        check("t4_gnt", 32'(gnt[0]), 32'h7);
        @(posedge clk);
        #1;
        req[0] = '0;
        @(negedge clk);
        check("t4_rvalid", 32'(rvalid[0]), 32'h7);
        check("t4_cnt", cnt[0], 32'h0);

        // Same-bank conflict from cleared pointers.
        @(posedge clk);
        #1;
        clear[0] = 1'b1;
        @(posedge clk);
        #1;
        clear[0] = 1'b0;
        req[0]   = 3'b111;
        for (int p = 0; p < 3; p++) begin
            add[0][p]  = 32'h0;
            exp_cur[p] = 32'h5A5A5A5A;
        end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("t3_gnt", 32'(gnt[0]), 32'(1) << (k % 3));
            check("t3_cnt", cnt[0], 32'(2 * k));
            @(posedge clk);
            #1;
        end
        req[0] = '0;
        @(negedge clk);
        check("t3_cnt_end", cnt[0], 32'd12);
        @(posedge clk);
        #1;
        clear[0] = 1'b1;
        @(posedge clk);
        #1;
        clear[0] = 1'b0;
        @(negedge clk);
        check("clear_cnt", cnt[0], 32'h0);
        for (int p = 0; p < 3; p++) check("dut0_queue_drained", 32'(expq[0][p].size()), 32'h0);

        // Random burst with stalls on instance 1.
        @(posedge clk);
        #1;
        issued     = 0;
        conf_model = 0;
        loops      = 0;
        gprev      = '0;
        while (issued < 1000 && loops < 20000) begin
            loops++;
            for (int p = 0; p < 3; p++) begin
                if (req[1][p] && gprev[p]) req[1][p] = 1'b0;
                if (!req[1][p] && issued < 1000 && $urandom_range(0, 3) != 0) begin
                    req[1][p]  = 1'b1;
                    wen[1][p]  = 1'($urandom_range(0, 1));
                    add[1][p]  = (32'($urandom_range(0, 7)) << 2) |
                                 (32'($urandom_range(0, 1)) << 12) | 32'($urandom_range(0, 3));
                    wdat[1][p] = $urandom;
                    be[1][p]   = ($urandom_range(0, 1) != 0) ? 4'hF : 4'($urandom);
                    issued++;
                end
            end
            @(negedge clk);
            gprev      = gnt[1];
            conf_model = conf_model + $countones(req[1] & ~gnt[1]);
            @(posedge clk);
            #1;
        end
        check("t6_issued", 32'(issued), 32'd1000);
        for (int p = 0; p < 3; p++) begin
            if (req[1][p] && gprev[p]) req[1][p] = 1'b0;
        end
        @(negedge clk);
        check("t6_conflict_cnt", cnt[1], 32'(conf_model));

        // Reset in the middle of the burst.
        @(posedge clk);
        #1;
        rst_n[1] = 1'b0;
        req[1]   = 3'b111;
        @(negedge clk);
        check("t6_gnt_in_reset", 32'(gnt[1]), 32'h0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("t6_rst_rvalid", 32'(rvalid[1]), 32'h0);
        check("t6_rst_gnt", 32'(gnt[1]), 32'h0);
        check("t6_rst_cnt", cnt[1], 32'h0);
        @(posedge clk);
        #1;
        req[1]   = '0;
        rst_n[1] = 1'b1;
        @(negedge clk);
        for (int p = 0; p < 3; p++) check("dut1_queue_drained", 32'(expq[1][p].size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
